// File: rtl/sc_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO family.
package sc_fifo_pkg;

  localparam int SA_NORMAL    = 0;
  localparam int SA_SHOWAHEAD = 1;

  // Show-ahead output stage: whether the head word is parked on dout.
  typedef enum logic {
    OS_IDLE  = 1'b0,
    OS_VALID = 1'b1
  } out_state_t;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable and clear.
module sc_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the FIFO's dout, so it follows reset and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/sc_fifo_pro.sv
// Single-clock FIFO with normal or show-ahead read, level flags and error pulses.
module sc_fifo_pro
  import sc_fifo_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 10,
  parameter int SHOW_AHEAD = SA_NORMAL,
  parameter int AFULL_TH   = 2**AW - 2,
  parameter int AEMPTY_TH  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          write,
  input  logic          read,
  output logic [DW-1:0] dout,
  output logic [AW:0]   data_cnt,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH    = fifo_depth(AW);
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  generate
    if (AFULL_TH <= 0 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_param
      $fatal(1, "sc_fifo_pro: illegal AFULL_TH/AEMPTY_TH for AW");
    end
  endgenerate

  logic [AW:0] wptr, rptr, cnt, ram_cnt;
  logic        wr_ok, rd_ok, ram_re;
  out_state_t  os_q, os_d;

  assign ram_cnt      = wptr - rptr;
  assign data_cnt     = cnt;
  assign full         = (cnt == DEPTH_V);
  assign almost_full  = (cnt >= AFULL_V);
  assign almost_empty = (cnt <= AEMPTY_V);
  assign empty        = (SHOW_AHEAD == SA_SHOWAHEAD) ? (os_q == OS_IDLE) : (cnt == '0);

  // In show-ahead mode the RAM prefetches whenever the output slot is free or being acknowledged.
  always_comb begin
    wr_ok  = write && !full && !clr;
    rd_ok  = read && !empty && !clr;
    os_d   = os_q;
    ram_re = 1'b0;
    if (SHOW_AHEAD == SA_SHOWAHEAD) begin
      if (ram_cnt != '0 && (os_q == OS_IDLE || rd_ok)) begin
        ram_re = 1'b1;
        os_d   = OS_VALID;
      end else if (rd_ok) begin
        os_d = OS_IDLE;
      end
    end else begin
      ram_re = rd_ok;
    end
    if (clr) begin
      os_d   = OS_IDLE;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) os_q <= OS_IDLE;
    else     os_q <= os_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)  wptr <= wptr + PTR_ONE;
      if (ram_re) rptr <= rptr + PTR_ONE;
      if (wr_ok && !rd_ok)      cnt <= cnt + PTR_ONE;
      else if (rd_ok && !wr_ok) cnt <= cnt - PTR_ONE;
      overflow  <= write && full;
      underflow <= read && empty;
    end
  end

  sc_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (rptr[AW-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sc_fifo_pro.sv
// Bench for sc_fifo_pro: queue model for normal mode plus directed show-ahead vectors.
module tb_sc_fifo_pro;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_n, write_n, read_n;
  logic [7:0] din_n, dout_n;
  logic [3:0] cnt_n;
  logic       full_n, empty_n, af_n, ae_n, ovf_n, unf_n;
  logic       clr_s, write_s, read_s;
  logic [7:0] din_s, dout_s;
  logic [3:0] cnt_s;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_unf  = 1'b0;

  always #5 clk = ~clk;

  sc_fifo_pro #(.DW(8), .AW(3), .SHOW_AHEAD(0), .AFULL_TH(6), .AEMPTY_TH(1)) dut_n (
    .clk(clk), .rst(rst), .clr(clr_n), .din(din_n), .write(write_n), .read(read_n),
    .dout(dout_n), .data_cnt(cnt_n), .full(full_n), .empty(empty_n),
    .almost_full(af_n), .almost_empty(ae_n), .overflow(ovf_n), .underflow(unf_n)
  );

  sc_fifo_pro #(.DW(8), .AW(3), .SHOW_AHEAD(1), .AFULL_TH(6), .AEMPTY_TH(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr_s), .din(din_s), .write(write_s), .read(read_s),
    .dout(dout_s), .data_cnt(cnt_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s)
  );

  task automatic checkLiteral(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkLiteral("model_cnt",    cnt_n,   mq.size());
    checkLiteral("model_full",   full_n,  int'(mq.size() == 8));
    checkLiteral("model_empty",  empty_n, int'(mq.size() == 0));
    checkLiteral("model_afull",  af_n,    int'(mq.size() >= 6));
    checkLiteral("model_aempty", ae_n,    int'(mq.size() <= 1));
    checkLiteral("model_dout",   dout_n,  m_dout);
    checkLiteral("model_ovf",    ovf_n,   m_ovf);
    checkLiteral("model_unf",    unf_n,   m_unf);
  endtask

  // Normal-mode reference: a queue advanced by the FIFO's accept/reject rules.
  always @(posedge clk or posedge rst) begin
    if (rst || clr_n) begin
      mq.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == 8);
      was_empty = (mq.size() == 0);
      m_ovf = write_n && was_full;
      m_unf = read_n && was_empty;
      if (read_n && !was_empty) m_dout = mq.pop_front();
      if (write_n && !was_full) mq.push_back(din_n);
    end
  end

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    write_n = w;
    read_n  = r;
    clr_n   = c;
    din_n   = d;
    @(posedge clk);
    #1;
    write_n = 1'b0;
    read_n  = 1'b0;
    clr_n   = 1'b0;
  endtask

  task automatic applyShow(input logic w, input logic r, input logic [7:0] d);
    write_s = w;
    read_s  = r;
    din_s   = d;
    @(posedge clk);
    #1;
    write_s = 1'b0;
    read_s  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst = 1'b1;
    clr_n = 1'b0; write_n = 1'b0; read_n = 1'b0; din_n = 8'h00;
    clr_s = 1'b0; write_s = 1'b0; read_s = 1'b0; din_s = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkLiteral("rst_dout",   dout_n,  0);
    checkLiteral("rst_cnt",    cnt_n,   0);
    checkLiteral("rst_empty",  empty_n, 1);
    checkLiteral("rst_full",   full_n,  0);
    checkLiteral("rst_afull",  af_n,    0);
    checkLiteral("rst_aempty", ae_n,    1);
    checkLiteral("rst_sa_empty", empty_s, 1);
    rst = 1'b0;

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(16 + i));
      if (i == 4) checkLiteral("afull_at5", af_n, 0);
      if (i == 5) checkLiteral("afull_at6", af_n, 1);
    end
    checkLiteral("full_at8", full_n, 1);
    checkLiteral("cnt_at8", cnt_n, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99);
    checkLiteral("ovf_9th", ovf_n, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkLiteral("ovf_single", ovf_n, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkLiteral($sformatf("drain%0d", i), dout_n, 16 + i);
    end
    checkLiteral("empty_after_drain", empty_n, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkLiteral("unf_empty_read", unf_n, 1);

    // Simultaneous read and write across pointer wraps
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(64 + i));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(68 + i));
      checkLiteral($sformatf("rw_dout%0d", i), dout_n, 64 + i);
      checkLiteral($sformatf("rw_cnt%0d", i), cnt_n, 4);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkLiteral($sformatf("rw_tail%0d", i), dout_n, 84 + i);
    end

    // Full boundary with write and read together
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(96 + i));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
    checkLiteral("fb_dout", dout_n, 8'h60);
    checkLiteral("fb_ovf",  ovf_n, 1);
    checkLiteral("fb_cnt",  cnt_n, 7);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkLiteral($sformatf("fb_drain%0d", i), dout_n, 97 + i);
    end

    // Flush with concurrent write, then asynchronous reset
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(112 + i));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA);
    checkLiteral("clr_cnt",   cnt_n,   0);
    checkLiteral("clr_empty", empty_n, 1);
    checkLiteral("clr_ovf",   ovf_n,   0);
    checkLiteral("clr_dout",  dout_n,  0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(49 + i));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkLiteral("refill_dout", dout_n, 8'h31);
    #2 rst = 1'b1;
    #1;
    checkLiteral("arst_cnt",    cnt_n,   0);
    checkLiteral("arst_empty",  empty_n, 1);
    checkLiteral("arst_dout",   dout_n,  0);
    checkLiteral("arst_full",   full_n,  0);
    checkLiteral("arst_aempty", ae_n,    1);
    checkLiteral("arst_afull",  af_n,    0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkLiteral("post_rst_dout", dout_n, 8'h3C);

    // Show-ahead mode
    applyShow(1'b1, 1'b0, 8'hA5);
    waited = 0;
    while (empty_s && waited < 2) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkLiteral("sa_empty_fall", empty_s, 0);
    checkLiteral("sa_dout_head",  dout_s,  8'hA5);
    checkLiteral("sa_cnt1",       cnt_s,   1);
    applyShow(1'b0, 1'b1, 8'h00);
    checkLiteral("sa_empty_after_ack", empty_s, 1);
    checkLiteral("sa_dout_hold",       dout_s,  8'hA5);
    applyShow(1'b0, 1'b1, 8'h00);
    checkLiteral("sa_unf", unf_s, 1);
    applyShow(1'b1, 1'b0, 8'h11);
    applyShow(1'b1, 1'b0, 8'h22);
    applyShow(1'b0, 1'b0, 8'h00);
    checkLiteral("sa_two_head", dout_s, 8'h11);
    checkLiteral("sa_two_cnt",  cnt_s,  2);
    applyShow(1'b0, 1'b1, 8'h00);
    checkLiteral("sa_next_word", dout_s, 8'h22);
    checkLiteral("sa_next_empty", empty_s, 0);
    applyShow(1'b0, 1'b1, 8'h00);
    checkLiteral("sa_drained", empty_s, 1);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_fifo_pro.md
SC_FIFO_PRO -- requirements
Module: sc_fifo_pro

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DW, 8, data width.
- AW, 10, address width; capacity 2**AW words.
- SHOW_AHEAD, 0, 0 = normal read, 1 = show-ahead/FWFT.
- AFULL_TH, 2**AW-2, almost_full threshold.
- AEMPTY_TH, 1, almost_empty threshold.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- clr, in, 1, synchronous flush.
- din, in, DW, write data.
- write, in, 1, write request.
- read, in, 1, read request/acknowledge.
- dout, out, DW, read data.
- data_cnt, out, AW+1, stored word count, 0..2**AW.
- full, out, 1, data_cnt == 2**AW.
- empty, out, 1, no readable word.
- almost_full, out, 1, data_cnt >= AFULL_TH.
- almost_empty, out, 1, data_cnt <= AEMPTY_TH.
- overflow, out, 1, one-cycle pulse on a rejected write.
- underflow, out, 1, one-cycle pulse on a rejected read.

Function
REQ-003 Pointers SHALL be AW+1 bits and wrap modulo 2**(AW+1); the RAM is addressed by the low AW bits; full capacity 2**AW is usable.
REQ-004 A write SHALL be accepted when write=1 and full=0; a write while full SHALL be dropped and SHALL pulse overflow the next cycle, even if read=1 in that cycle.
REQ-005 A read SHALL be accepted when read=1 and empty=0; a read while empty SHALL be ignored and SHALL pulse underflow the next cycle, even if write=1 in that cycle.
REQ-006 An accepted write and an accepted read in the same cycle SHALL leave data_cnt unchanged; both pointers SHALL advance.
REQ-007 data_cnt, full, almost_full and almost_empty SHALL reflect state registered at the previous edge, with no combinational path from write/read.
REQ-008 In SHOW_AHEAD=0 mode:
- dout SHALL present the word read by an accepted read on the cycle after that read (latency 1).
- dout SHALL hold until the next accepted read.
- empty SHALL equal (data_cnt == 0).
REQ-009 In SHOW_AHEAD=1 mode:
- dout SHALL present the head word whenever empty=0; read acts as an acknowledge.
- The next word SHALL appear on dout the cycle after an accepted read.
- After a write into an empty FIFO, empty SHALL fall no later than 2 cycles after the write edge.
- dout SHALL hold its last value while empty=1.
REQ-010 clr=1 SHALL:
- reset both pointers;
- set data_cnt to 0 and empty to 1;
- set dout to 0 on the next edge;
- override write and read in the same cycle, with no overflow or underflow pulse.
REQ-011 Wrap-around SHALL be seamless: data order SHALL be preserved across any number of pointer wraps.
REQ-012 Parameter legality SHALL be checked at elaboration: 0 < AFULL_TH <= 2**AW and 0 <= AEMPTY_TH < 2**AW; violation SHALL be a fatal error.

Reset
REQ-013 rst=1 SHALL asynchronously force:
- pointers to 0, data_cnt to 0, dout to 0;
- empty=1, full=0, almost_full=0, almost_empty=1;
- overflow=0, underflow=0.
REQ-014 Reset asserted mid-operation SHALL discard all stored words; the first accepted write after release SHALL be the first word read.
REQ-015 Reset release SHALL be synchronised externally; the block SHALL accept requests from the first edge after rst falls.

Structure
REQ-016 A shared package sc_fifo_pkg SHALL hold the mode constants (SA_NORMAL=0, SA_SHOWAHEAD=1) and a function computing capacity from AW.
REQ-017 Storage SHALL be one sub-module, sc_fifo_ram: simple dual-port RAM, DW x 2**AW, synchronous write, registered read with read-enable; mode logic stays in sc_fifo_pro.

Verification (DW=8, AW=3, capacity 8, AFULL_TH=6, AEMPTY_TH=1)
REQ-018 Fill and drain, normal mode: write 0x10..0x17 on 8 consecutive cycles.
- Required: full=1 after the 8th write; almost_full=1 from data_cnt=6.
- A 9th write pulses overflow.
- Reading 8 times yields 0x10..0x17, each on the cycle after its read.
REQ-019 Show-ahead, SHOW_AHEAD=1: write 0xA5 into an empty FIFO.
- Required: empty falls within 2 cycles and dout=0xA5 before any read.
- One read: empty=1 next cycle.
- A further read pulses underflow.
REQ-020 Simultaneous read and write: hold 4 words, then assert write and read together for 20 cycles with incrementing data.
- Required: data_cnt stays 4 throughout.
- Output order is exact across 2+ pointer wraps.
REQ-021 Full boundary: with the FIFO full, assert write=1 and read=1 together.
- Required: read accepted, write dropped, overflow pulse.
- data_cnt becomes 7.
REQ-022 Flush and reset: with 5 words stored, pulse clr together with write.
- Required: data_cnt=0, empty=1, no overflow.
- Refill 3 words, then assert rst asynchronously between edges: all outputs take reset values immediately.
- Next write 0x3C reads back as 0x3C.
